// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Merges ALU and memory-load writeback requests onto the single register-file
// write port. Each requester owns a DEPTH-entry FIFO. At most one entry is
// granted per cycle. When both FIFOs are waiting, a round-robin pointer picks
// the side, and the granted entry appears on the registered write port on the
// same clock edge that removes it from its FIFO.
// Optional build macro RF_WB_FWD_EN adds a combinational lookup port
// (fwd_reg -> fwd_hit/fwd_dat) over every queued entry and the write-port stage.

module rf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_dat,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_reg,
    input  logic [31:0] m_dat,
    output logic        RegWrite,
    output logic [4:0]  regW,
    output logic [31:0] Wdat,
    output logic        wb_busy
`ifdef RF_WB_FWD_EN
    ,
    input  logic [4:0]  fwd_reg,
    output logic        fwd_hit,
    output logic [31:0] fwd_dat
`endif
);

    // Requester slots: index 0 is the ALU side, index 1 the memory-load side
    localparam int NREQ  = 2;
    localparam int IDX_A = 0;
    localparam int IDX_M = 1;

    // Each entry is {reg[4:0], dat[31:0]}
    localparam int EW = 37;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // Round-robin pointer names the side that wins the next contested grant
    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_M = 1'b1
    } side_t;

    // FIFO storage and bookkeeping, one set per requester
    logic [EW-1:0] r_mem   [NREQ][DEPTH];
    logic [PW-1:0] r_rdPtr [NREQ];
    logic [PW-1:0] r_wrPtr [NREQ];
    logic [CW-1:0] r_count [NREQ];

    side_t r_rrPtr;
    side_t w_rrNext;

    logic [NREQ-1:0]         w_valid;
    logic [NREQ-1:0]         w_ready;
    logic [NREQ-1:0]         w_push;
    logic [NREQ-1:0]         w_notEmpty;
    logic [NREQ-1:0]         w_pop;
    logic [NREQ-1:0][EW-1:0] w_inData;
    logic [NREQ-1:0][EW-1:0] w_head;

    logic          w_contested;
    logic          w_grantAny;
    logic [EW-1:0] w_grantEntry;

    // Registered write port
    logic          r_regWrite;
    logic [4:0]    r_regW;
    logic [31:0]   r_wdat;

    assign w_valid           = {m_valid, a_valid};
    assign w_inData[IDX_A]   = {a_reg, a_dat};
    assign w_inData[IDX_M]   = {m_reg, m_dat};

    // Per-requester status derived only from stored state, so ready never
    // depends on whether the same FIFO is being popped this cycle
    always_comb begin
        for (int s = 0; s < NREQ; s++) begin
            w_notEmpty[s] = (r_count[s] != '0);
            w_ready[s]    = !Rst && (r_count[s] < CNT_FULL);
            w_push[s]     = w_valid[s] && w_ready[s];
            w_head[s]     = r_mem[s][r_rdPtr[s]];
        end
    end

    // Single grant per cycle: the only waiting side, or the round-robin side
    // when both are waiting
    assign w_contested  = w_notEmpty[IDX_A] && w_notEmpty[IDX_M];
    assign w_pop[IDX_A] = w_notEmpty[IDX_A] && (!w_notEmpty[IDX_M] || (r_rrPtr == SIDE_A));
    assign w_pop[IDX_M] = w_notEmpty[IDX_M] && (!w_notEmpty[IDX_A] || (r_rrPtr == SIDE_M));
    assign w_grantAny   = |w_pop;
    assign w_grantEntry = w_pop[IDX_A] ? w_head[IDX_A] : w_head[IDX_M];

    // FIFO storage: write accepted entries at the tail
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int s = 0; s < NREQ; s++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[s][i] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < NREQ; s++) begin
                if (w_push[s]) begin
                    r_mem[s][r_wrPtr[s]] <= w_inData[s];
                end
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a
    // power of two, and a simultaneous push and pop leaves the count alone
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int s = 0; s < NREQ; s++) begin
                r_rdPtr[s] <= '0;
                r_wrPtr[s] <= '0;
                r_count[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NREQ; s++) begin
                if (w_push[s]) begin
                    r_wrPtr[s] <= r_wrPtr[s] + PTR_ONE;
                end
                if (w_pop[s]) begin
                    r_rdPtr[s] <= r_rdPtr[s] + PTR_ONE;
                end
                if (w_push[s] && !w_pop[s]) begin
                    r_count[s] <= r_count[s] + CNT_ONE;
                end else if (!w_push[s] && w_pop[s]) begin
                    r_count[s] <= r_count[s] - CNT_ONE;
                end
            end
        end
    end

    // Round-robin state register
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_rrPtr <= SIDE_A;
        end else begin
            r_rrPtr <= w_rrNext;
        end
    end

    // Round-robin next state: only a contested grant moves the pointer, and
    // it moves to the side that lost
    always_comb begin
        w_rrNext = r_rrPtr;
        if (w_contested) begin
            w_rrNext = w_pop[IDX_A] ? SIDE_M : SIDE_A;
        end
    end

    // Write port: a granted entry with a non-zero register becomes a one-cycle
    // write; register 0 entries are swallowed and regW/Wdat keep their value
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_regWrite <= 1'b0;
            r_regW     <= '0;
            r_wdat     <= '0;
        end else begin
            r_regWrite <= 1'b0;
            if (w_grantAny && (w_grantEntry[36:32] != 5'd0)) begin
                r_regWrite <= 1'b1;
                r_regW     <= w_grantEntry[36:32];
                r_wdat     <= w_grantEntry[31:0];
            end
        end
    end

    assign a_ready  = w_ready[IDX_A];
    assign m_ready  = w_ready[IDX_M];
    assign RegWrite = r_regWrite;
    assign regW     = r_regW;
    assign Wdat     = r_wdat;
    assign wb_busy  = w_notEmpty[IDX_A] || w_notEmpty[IDX_M] || r_regWrite;

`ifdef RF_WB_FWD_EN
    logic          w_queueHit;
    logic [31:0]   w_queueDat;
    logic [PW-1:0] w_slot;

    // Queued-entry lookup: scan each FIFO from oldest to newest so the newest
    // match overwrites older ones
    always_comb begin
        w_queueHit = 1'b0;
        w_queueDat = '0;
        w_slot     = '0;
        for (int s = 0; s < NREQ; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_slot = r_rdPtr[s] + PW'(i);
                if ((CW'(i) < r_count[s]) && (r_mem[s][w_slot][36:32] == fwd_reg)) begin
                    w_queueHit = 1'b1;
                    w_queueDat = r_mem[s][w_slot][31:0];
                end
            end
        end
    end

    // Forwarding result: queued values are newer than the write-port stage,
    // and register 0 never forwards
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        if (fwd_reg != 5'd0) begin
            if (w_queueHit) begin
                fwd_hit = 1'b1;
                fwd_dat = w_queueDat;
            end else if (r_regWrite && (r_regW == fwd_reg)) begin
                fwd_hit = 1'b1;
                fwd_dat = r_wdat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Directed bench for rf_wb_arbiter. A queue-based reference model tracks the
// two requester queues, the round-robin choice and the write port; a compare
// process checks every output against it on each falling edge. Hand-computed
// literal checks pin the key scenarios. Define RF_WB_FWD_EN to also cover the
// forwarding port.

module tb_rf_wb_arbiter;

    localparam int DEPTH    = 2;
    localparam int CLK_HALF = 5;

    logic        clk = 1'b0;
    logic        Rst;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_dat;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_reg;
    logic [31:0] m_dat;
    logic        RegWrite;
    logic [4:0]  regW;
    logic [31:0] Wdat;
    logic        wb_busy;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fwd_reg;
    logic        fwd_hit;
    logic [31:0] fwd_dat;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [36:0] qA[$];
    logic [36:0] qM[$];
    bit          rrToM = 1'b0;
    bit          expWe = 1'b0;
    logic [4:0]  expReg = '0;
    logic [31:0] expDat = '0;

    always #CLK_HALF clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .Rst      (Rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_reg    (a_reg),
        .a_dat    (a_dat),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_reg    (m_reg),
        .m_dat    (m_dat),
        .RegWrite (RegWrite),
        .regW     (regW),
        .Wdat     (Wdat),
        .wb_busy  (wb_busy)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_reg  (fwd_reg),
        .fwd_hit  (fwd_hit),
        .fwd_dat  (fwd_dat)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's worth of requester inputs, then move just past the edge
    task automatic applyStimulus(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                                 input logic mV, input logic [4:0] mR, input logic [31:0] mD);
        a_valid = aV;
        a_reg   = aR;
        a_dat   = aD;
        m_valid = mV;
        m_reg   = mR;
        m_dat   = mD;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
    endtask

    task automatic pulseReset();
        a_valid = 1'b0;
        m_valid = 1'b0;
        Rst     = 1'b1;
        @(posedge clk);
        #1;
        Rst = 1'b0;
        #1;
    endtask

    // Model step at each edge: reset empties everything; otherwise one entry
    // is granted from the queue contents held before the edge, then accepted
    // pushes join the back of their queues
    task automatic modelStep();
        logic [36:0] ent;
        bit pushA, pushM, takeA, takeM;
        if (Rst) begin
            qA.delete();
            qM.delete();
            rrToM  = 1'b0;
            expWe  = 1'b0;
            expReg = '0;
            expDat = '0;
            return;
        end
        pushA = a_valid && (qA.size() < DEPTH);
        pushM = m_valid && (qM.size() < DEPTH);
        takeA = 1'b0;
        takeM = 1'b0;
        if (qA.size() != 0 && qM.size() != 0) begin
            if (rrToM) takeM = 1'b1;
            else       takeA = 1'b1;
            rrToM = !rrToM;
        end else if (qA.size() != 0) begin
            takeA = 1'b1;
        end else if (qM.size() != 0) begin
            takeM = 1'b1;
        end
        expWe = 1'b0;
        ent   = '0;
        if (takeA) ent = qA.pop_front();
        if (takeM) ent = qM.pop_front();
        if ((takeA || takeM) && ent[36:32] != 5'd0) begin
            expWe  = 1'b1;
            expReg = ent[36:32];
            expDat = ent[31:0];
        end
        if (pushA) qA.push_back({a_reg, a_dat});
        if (pushM) qM.push_back({m_reg, m_dat});
    endtask

    // Compare every DUT output against the model
    task automatic compareAll();
        bit          expBusy;
`ifdef RF_WB_FWD_EN
        bit          expHit;
        logic [31:0] expFwd;
`endif
        expBusy = (qA.size() != 0) || (qM.size() != 0) || expWe;
        checkOutput("cyc_a_ready",  32'(a_ready),  32'(!Rst && (qA.size() < DEPTH)));
        checkOutput("cyc_m_ready",  32'(m_ready),  32'(!Rst && (qM.size() < DEPTH)));
        checkOutput("cyc_regwrite", 32'(RegWrite), 32'(expWe));
        checkOutput("cyc_regw",     32'(regW),     32'(expReg));
        checkOutput("cyc_wdat",     Wdat,          expDat);
        checkOutput("cyc_wb_busy",  32'(wb_busy),  32'(expBusy));
`ifdef RF_WB_FWD_EN
        expHit = 1'b0;
        expFwd = '0;
        if (fwd_reg != 5'd0) begin
            for (int i = qA.size() - 1; i >= 0 && !expHit; i--) begin
                if (qA[i][36:32] == fwd_reg) begin
                    expHit = 1'b1;
                    expFwd = qA[i][31:0];
                end
            end
            for (int i = qM.size() - 1; i >= 0 && !expHit; i--) begin
                if (qM[i][36:32] == fwd_reg) begin
                    expHit = 1'b1;
                    expFwd = qM[i][31:0];
                end
            end
            if (!expHit && expWe && expReg == fwd_reg) begin
                expHit = 1'b1;
                expFwd = expDat;
            end
        end
        checkOutput("cyc_fwd_hit", 32'(fwd_hit), 32'(expHit));
        checkOutput("cyc_fwd_dat", fwd_dat, expFwd);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge Rst);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            compareAll();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int aSent;
        int mSent;
        int cyc;
        bit aGo;
        bit mGo;

        Rst     = 1'b0;
        a_valid = 1'b0;
        a_reg   = '0;
        a_dat   = '0;
        m_valid = 1'b0;
        m_reg   = '0;
        m_dat   = '0;
`ifdef RF_WB_FWD_EN
        fwd_reg = '0;
`endif
        #1;
        Rst = 1'b1;
        #1;
        // Everything forced low while reset is held
        checkOutput("rst_a_ready",  32'(a_ready),  32'd0);
        checkOutput("rst_m_ready",  32'(m_ready),  32'd0);
        checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("rst_regw",     32'(regW),     32'd0);
        checkOutput("rst_wdat",     Wdat,          32'd0);
        checkOutput("rst_wb_busy",  32'(wb_busy),  32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        Rst = 1'b0;
        #1;
        checkOutput("post_rst_a_ready", 32'(a_ready), 32'd1);
        checkOutput("post_rst_m_ready", 32'(m_ready), 32'd1);

        // Single ALU write {3, 0x11}
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        checkOutput("t1_push_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("t1_push_busy",     32'(wb_busy),  32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t1_wr_regwrite", 32'(RegWrite), 32'd1);
        checkOutput("t1_wr_regw",     32'(regW),     32'd3);
        checkOutput("t1_wr_wdat",     Wdat,          32'h11);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t1_done_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("t1_done_regw",     32'(regW),     32'd3);
        checkOutput("t1_done_busy",     32'(wb_busy),  32'd0);

        // Both sides hold two entries: writes must alternate A0, M0, A1, M1
        pulseReset();
        applyStimulus(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hB0);
        applyStimulus(1'b1, 5'd4, 32'hA1, 1'b1, 5'd6, 32'hB1);
        checkOutput("t2_w0_regw", 32'(regW), 32'd1);
        checkOutput("t2_w0_wdat", Wdat,      32'hA0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t2_w1_regw", 32'(regW), 32'd2);
        checkOutput("t2_w1_wdat", Wdat,      32'hB0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t2_w2_regw", 32'(regW), 32'd4);
        checkOutput("t2_w2_wdat", Wdat,      32'hA1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t2_w3_regw",     32'(regW),     32'd6);
        checkOutput("t2_w3_wdat",     Wdat,          32'hB1);
        checkOutput("t2_w3_regwrite", 32'(RegWrite), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t2_end_regwrite", 32'(RegWrite), 32'd0);

        // Register 0 entry is consumed without a write
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        checkOutput("t3_push_busy", 32'(wb_busy), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t3_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("t3_regw",     32'(regW),     32'd6);
        checkOutput("t3_wdat",     Wdat,          32'hB1);
        checkOutput("t3_busy",     32'(wb_busy),  32'd0);

        // Both sides push continuously: queues fill, ready throttles, ten
        // entries per side pass through with pointer wrap
        pulseReset();
        aSent = 0;
        mSent = 0;
        cyc   = 0;
        while ((aSent < 10 || mSent < 10) && cyc < 200) begin
            aGo = (aSent < 10) && a_ready;
            mGo = (mSent < 10) && m_ready;
            applyStimulus(aSent < 10, 5'(8 + aSent), 32'h1000 + 32'(aSent),
                          mSent < 10, 5'(20 + mSent), 32'h2000 + 32'(mSent));
            if (aGo) aSent++;
            if (mGo) mSent++;
            cyc++;
            if (cyc == 2) begin
                checkOutput("t4_c2_a_ready", 32'(a_ready), 32'd1);
                checkOutput("t4_c2_m_ready", 32'(m_ready), 32'd0);
            end
            if (cyc == 3) begin
                checkOutput("t4_c3_a_ready", 32'(a_ready), 32'd0);
                checkOutput("t4_c3_m_ready", 32'(m_ready), 32'd1);
            end
        end
        checkOutput("t4_push_budget", 32'(cyc >= 200), 32'd0);
        idleCycles(8);
        checkOutput("t4_drained_busy", 32'(wb_busy), 32'd0);

        // Reset with three entries queued and a write in flight
        pulseReset();
        applyStimulus(1'b1, 5'd7,  32'h70, 1'b1, 5'd9,  32'h90);
        applyStimulus(1'b1, 5'd10, 32'h71, 1'b1, 5'd11, 32'h91);
        checkOutput("t5_pre_regwrite", 32'(RegWrite), 32'd1);
        checkOutput("t5_pre_regw",     32'(regW),     32'd7);
        a_valid = 1'b0;
        m_valid = 1'b0;
        Rst     = 1'b1;
        #1;
        checkOutput("t5_rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("t5_rst_a_ready",  32'(a_ready),  32'd0);
        checkOutput("t5_rst_m_ready",  32'(m_ready),  32'd0);
        checkOutput("t5_rst_busy",     32'(wb_busy),  32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        Rst = 1'b0;
        #1;
        checkOutput("t5_rel_a_ready", 32'(a_ready), 32'd1);
        checkOutput("t5_rel_m_ready", 32'(m_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("t5_after_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("t5_after_busy",     32'(wb_busy),  32'd0);

`ifdef RF_WB_FWD_EN
        // Forwarding: A ends up holding {5,0x1},{5,0x2} while M holds {13,0xD}
        pulseReset();
        applyStimulus(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
        applyStimulus(1'b1, 5'd5,  32'h1, 1'b1, 5'd13, 32'hD);
        applyStimulus(1'b1, 5'd5,  32'h2, 1'b0, 5'd0,  32'd0);
        a_valid = 1'b0;
        checkOutput("t6_a_full", 32'(a_ready), 32'd0);
        fwd_reg = 5'd5;
        #1;
        checkOutput("t6_r5_hit", 32'(fwd_hit), 32'd1);
        checkOutput("t6_r5_dat", fwd_dat,      32'h2);
        fwd_reg = 5'd0;
        #1;
        checkOutput("t6_r0_hit", 32'(fwd_hit), 32'd0);
        checkOutput("t6_r0_dat", fwd_dat,      32'd0);
        fwd_reg = 5'd12;
        #1;
        checkOutput("t6_r12_hit", 32'(fwd_hit), 32'd1);
        checkOutput("t6_r12_dat", fwd_dat,      32'hC);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        fwd_reg = 5'd5;
        #1;
        checkOutput("t6_prec_hit", 32'(fwd_hit), 32'd1);
        checkOutput("t6_prec_dat", fwd_dat,      32'h2);
        fwd_reg = 5'd13;
        #1;
        checkOutput("t6_r13_dat", fwd_dat, 32'hD);
        fwd_reg = 5'd30;
        #1;
        checkOutput("t6_r30_hit", 32'(fwd_hit), 32'd0);
        fwd_reg = 5'd0;
        idleCycles(6);
`endif

        idleCycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
